// File: rtl/btn_cmd_conditioner.sv
// ============================================================================
// Module      : btn_cmd_conditioner
// Description : Synchronizes and debounces three raw buttons, turns press edges
//               into prioritized commands held in a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_cmd_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_raw,
  input  logic       cmd_ready,
  input  logic       clr_ovf,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       ovf,
  output logic [2:0] db_level
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_db;
  logic [2:0] r_db_q;
  logic [2:0] r_cmd;
  logic       r_cmd_valid;
  logic       r_ovf;

  logic [2:0] w_press;
  logic       w_any_press;
  logic       w_multi_press;
  logic [2:0] w_enc;
  logic       w_load;
  logic       w_set_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample matching the current level restarts the count, so only an
  // unbroken run of DB_CYCLES differing samples flips the debounced level.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_sync2[i] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_db  <= r_sync2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_db[i] = r_db;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_q <= 3'b000;
    end else begin
      r_db_q <= w_db;
    end
  end

  always_comb begin
    w_press       = w_db & ~r_db_q;
    w_any_press   = |w_press;
    w_multi_press = (w_press & (w_press - 3'd1)) != 3'd0;
    w_enc         = 3'd0;
    if (w_press[2]) begin
      w_enc = 3'd3;
    end else if (w_press[1]) begin
      w_enc = 3'd2;
    end else if (w_press[0]) begin
      w_enc = 3'd1;
    end
    // A press can only enter when the slot is empty or draining this edge.
    w_load    = w_any_press && (!r_cmd_valid || cmd_ready);
    w_set_ovf = w_multi_press || (w_any_press && r_cmd_valid && !cmd_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= 3'd0;
      r_cmd_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_cmd       <= w_enc;
        r_cmd_valid <= 1'b1;
      end else if (r_cmd_valid && cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end

      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign ovf       = r_ovf;
  assign db_level  = w_db;

endmodule

`default_nettype wire

// File: tb/tb_btn_cmd_conditioner.sv
// ============================================================================
// Module      : tb_btn_cmd_conditioner
// Description : Scenario and randomized checks of btn_cmd_conditioner against
//               a sample-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_cmd_conditioner;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn_raw;
  logic       cmd_ready;
  logic       clr_ovf;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       ovf;
  logic [2:0] db_level;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw samples taken at each edge since reset.
  logic [2:0] hist[$];
  logic [2:0] m_db, m_dbq, m_cmd;
  logic       m_valid, m_ovf;

  btn_cmd_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .cmd_ready(cmd_ready),
    .clr_ovf  (clr_ovf),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .ovf      (ovf),
    .db_level (db_level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_db = 3'b000; m_dbq = 3'b000; m_cmd = 3'd0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  // A level flips once the last DB synchronized samples (raw delayed two
  // edges) all disagree with it; pre-reset history reads as zero.
  task automatic model_edge();
    logic [2:0] press, enc;
    logic       set_ovf, all_diff, s;
    int         n;
    hist.push_back(btn_raw);
    press = m_db & ~m_dbq;
    enc = press[2] ? 3'd3 : press[1] ? 3'd2 : press[0] ? 3'd1 : 3'd0;
    set_ovf = ($countones(press) > 1) || (press != 3'b000 && m_valid && !cmd_ready);
    if (press != 3'b000 && (!m_valid || cmd_ready)) begin
      m_cmd = enc; m_valid = 1'b1;
    end else if (m_valid && cmd_ready) begin
      m_valid = 1'b0;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_dbq = m_db;
    n = hist.size();
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = n - 2 - DB; k <= n - 3; k++) begin
        s = (k >= 0) ? hist[k][b] : 1'b0;
        if (s == m_db[b]) all_diff = 1'b0;
      end
      if (all_diff) m_db[b] = ~m_db[b];
    end
    if (hist.size() > 2 * DB) void'(hist.pop_front());
  endtask

  function automatic logic [8:0] obs_vec();
    return {db_level, cmd_valid, ovf, (cmd_valid ? cmd : 3'd0)};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_db, m_valid, m_ovf, (m_valid ? m_cmd : 3'd0)};
  endfunction

  // Drive on the falling edge, step the model at the rising edge, return at posedge+1.
  task automatic tick(input logic [2:0] raw, input logic rdy, input logic clr);
    @(negedge clk);
    btn_raw = raw; cmd_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(3'b000, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = 3'b000; cmd_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if ({db_level, cmd_valid, ovf, cmd} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", {db_level, cmd_valid, ovf, cmd}, 9'd0);
    end
    checks++;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(3'b000, 1'b1, 1'b0);
      if (cmd_valid !== 1'b0 || db_level !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_quiet k=%0d valid %b db %b exp 0 000", k, cmd_valid, db_level);
      end
      checks++;
    end
  endtask

  task automatic test_single_press();
    for (int k = 0; k <= 12; k++) begin
      tick(3'b001, 1'b1, 1'b0);
      if (cmd_valid !== (k == DB + 2) || db_level[0] !== (k >= DB + 1)) begin
        errors++;
        $display("FAIL single_latency k=%0d valid %b db0 %b exp %b %b",
                 k, cmd_valid, db_level[0], (k == DB + 2), (k >= DB + 1));
      end
      checks++;
      if (k == DB + 2 && cmd !== 3'd1) begin
        errors++;
        $display("FAIL single_cmd got %0d exp 1", cmd);
      end
      if (k == DB + 2) checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
    settle(DB + 6);
  endtask

  task automatic test_glitch();
    logic [2:0] raw;
    for (int k = 0; k < 27; k++) begin
      raw = (k < 7 || (k >= 8 && k < 15)) ? 3'b010 : 3'b000;
      tick(raw, 1'b1, 1'b0);
      if (cmd_valid !== 1'b0 || db_level !== 3'b000) begin
        errors++;
        $display("FAIL glitch k=%0d valid %b db %b exp 0 000", k, cmd_valid, db_level);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_multi();
    int n_valid = 0;
    settle(2);
    for (int k = 0; k < 14; k++) begin
      tick(3'b101, 1'b1, 1'b0);
      if (cmd_valid === 1'b1) begin
        n_valid++;
        if (cmd !== 3'd3) begin
          errors++;
          $display("FAIL multi_cmd got %0d exp 3", cmd);
        end
        checks++;
      end
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL multi_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
    if (n_valid != 1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL multi_once issued %0d ovf %b exp 1 1", n_valid, ovf);
    end
    checks++;
    settle(DB + 6);
  endtask

  task automatic test_drop();
    for (int k = 0; k < 12; k++) tick(3'b001, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      tick(3'b011, 1'b0, 1'b0);
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
    if (cmd_valid !== 1'b1 || cmd !== 3'd1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL drop_hold got valid %b cmd %0d ovf %b exp 1 1 1", cmd_valid, cmd, ovf);
    end
    checks++;
    tick(3'b011, 1'b1, 1'b0);
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_drain got valid %b exp 0", cmd_valid);
    end
    checks++;
    settle(DB + 6);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) tick(3'b001, 1'b0, 1'b0);
    for (int j = 0; j <= DB + 3; j++) begin
      tick(3'b011, (j == DB + 2), 1'b0);
      if (j == DB + 2 && (cmd_valid !== 1'b1 || cmd !== 3'd2 || ovf !== 1'b0)) begin
        errors++;
        $display("FAIL b2b_reload got valid %b cmd %0d ovf %b exp 1 2 0", cmd_valid, cmd, ovf);
      end
      if (j == DB + 2) checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model j=%0d got %b exp %b", j, obs_vec(), exp_vec());
      end
      checks++;
    end
    tick(3'b011, 1'b1, 1'b0);
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got valid %b exp 0", cmd_valid);
    end
    checks++;
    settle(DB + 6);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 12; k++) tick(3'b001, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(3'b101, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    if ({db_level, cmd_valid, ovf, cmd} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %b exp %b", {db_level, cmd_valid, ovf, cmd}, 9'd0);
    end
    checks++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= DB + 4; k++) begin
      tick(3'b101, 1'b1, 1'b0);
      if (cmd_valid !== (k == DB + 2)) begin
        errors++;
        $display("FAIL reset_mid_latency k=%0d valid %b exp %b", k, cmd_valid, (k == DB + 2));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
    settle(DB + 6);
  endtask

  task automatic test_random();
    logic [2:0] raw = 3'b000;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) raw = 3'($urandom_range(0, 7));
      tick(raw, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_multi();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
